// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// master = producer/consumer side, slave = multiplier side.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  product
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add unsigned multiplier, one WIDTH-bit ripple adder,
// WIDTH iterations per product, valid/ready on both sides.
module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH:0]       w_carry;
    logic                 w_cout;
    logic                 w_accept;
    logic                 w_release;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.product   = r_acc;

    assign w_accept  = bus.in_valid && (r_state == IDLE);
    assign w_release = bus.out_ready && (r_state == DONE);

    // Multiplicand is added only when the current multiplier LSB is set.
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;
    assign w_cout     = w_carry[WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        fullAdder u_fa (
            .i_a    (r_acc[WIDTH+g]),
            .i_b    (w_addend[g]),
            .i_cin  (w_carry[g]),
            .o_sum  (w_sum[g]),
            .o_cout (w_carry[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: accept in IDLE, WIDTH steps in BUSY, hold DONE until taken.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (r_count == LAST) w_next = DONE;
            DONE:    if (w_release) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: load operands, then shift the accumulator right with carry-in at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_mcand <= bus.a;
            r_acc   <= {{WIDTH{1'b0}}, bus.b};
            r_count <= '0;
        end else if (r_state == BUSY) begin
            r_acc   <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
            r_count <= r_count + 1'b1;
        end
    end
endmodule
